// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: full-duplex SPI slave in the fabric clock domain.
// Oversamples nCS/SCK/MOSI, assembles RX words into a small FWFT FIFO
// and shifts TX words out on MISO. All four SPI modes, either bit order.
module spi_slave_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             nCS,
  input  logic             SCK,
  input  logic             MOSI,
  output logic             MISO,
  output logic             miso_oe,
  output logic             chip_selected,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             new_transfer,
  output logic             transfer_done,
  output logic             rx_overflow,
  output logic             tx_underrun
);

  localparam int BW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);

  logic [2:0]       ncs_sync_reg;
  logic [2:0]       sck_sync_reg;
  logic [1:0]       mosi_sync_reg;
  logic             ncs_fall, ncs_rise, sck_rise, sck_fall, active;
  logic             sample_edge, shift_edge, mosi_bit;
  logic [WIDTH-1:0] rx_shift_reg, rx_shift_next;
  logic [BW-1:0]    bitcnt_reg;
  logic             word_done;
  logic [WIDTH-1:0] tx_reg, tx_shifted, load_word;
  logic             load_pending_reg, skip_first_reg, do_load;
  logic             tx_ready_reg, tx_underrun_reg, new_transfer_reg, transfer_done_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             fifo_full, do_pop, do_push, rx_overflow_reg;

  // Bring the asynchronous pins into clk; idle values avoid a false edge after reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ncs_sync_reg  <= 3'b111;
      sck_sync_reg  <= {3{CPOL}};
      mosi_sync_reg <= 2'b00;
    end else begin
      ncs_sync_reg  <= {ncs_sync_reg[1:0], nCS};
      sck_sync_reg  <= {sck_sync_reg[1:0], SCK};
      mosi_sync_reg <= {mosi_sync_reg[0], MOSI};
    end
  end

  // Edge detection on the two oldest stages; MOSI stage 1 lines up with SCK stage 1
  always_comb begin
    ncs_fall    = ncs_sync_reg[2] & ~ncs_sync_reg[1];
    ncs_rise    = ~ncs_sync_reg[2] & ncs_sync_reg[1];
    sck_rise    = ~sck_sync_reg[2] & sck_sync_reg[1];
    sck_fall    = sck_sync_reg[2] & ~sck_sync_reg[1];
    active      = ~ncs_sync_reg[2] & ~ncs_sync_reg[1];
    sample_edge = active & (SAMPLE_ON_RISE ? sck_rise : sck_fall);
    shift_edge  = active & (SAMPLE_ON_RISE ? sck_fall : sck_rise);
    mosi_bit    = mosi_sync_reg[1];
  end

  // Next RX shift value and end-of-word detect
  always_comb begin
    if (LSB_FIRST) rx_shift_next = {mosi_bit, rx_shift_reg[WIDTH-1:1]};
    else           rx_shift_next = {rx_shift_reg[WIDTH-2:0], mosi_bit};
    word_done = sample_edge && (bitcnt_reg == LAST_BIT);
  end

  // RX shift register and bit counter; deselect throws away a partial word
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_shift_reg <= '0;
      bitcnt_reg   <= '0;
    end else if (ncs_rise) begin
      rx_shift_reg <= '0;
      bitcnt_reg   <= '0;
    end else if (sample_edge) begin
      rx_shift_reg <= rx_shift_next;
      bitcnt_reg   <= (bitcnt_reg == LAST_BIT) ? '0 : bitcnt_reg + 1'b1;
    end
  end

  // TX load word (all-ones on underrun) and shifted value, filling with ones
  always_comb begin
    load_word = tx_valid ? tx_data : '1;
    if (LSB_FIRST) tx_shifted = {1'b1, tx_reg[WIDTH-1:1]};
    else           tx_shifted = {tx_reg[WIDTH-2:0], 1'b1};
    do_load = ncs_fall | (shift_edge & load_pending_reg);
  end

  // TX register: load on select and after each completed word, shift otherwise
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_reg           <= '1;
      load_pending_reg <= 1'b0;
      skip_first_reg   <= 1'b0;
    end else if (ncs_rise) begin
      load_pending_reg <= 1'b0;
      skip_first_reg   <= 1'b0;
    end else if (ncs_fall) begin
      tx_reg           <= load_word;
      load_pending_reg <= 1'b0;
      // With CPHA=1 bit 0 is already on MISO before the first shift edge
      skip_first_reg   <= CPHA;
    end else begin
      if (word_done) load_pending_reg <= 1'b1;
      if (shift_edge) begin
        if (load_pending_reg) begin
          tx_reg           <= load_word;
          load_pending_reg <= 1'b0;
        end else if (skip_first_reg) begin
          skip_first_reg <= 1'b0;
        end else begin
          tx_reg <= tx_shifted;
        end
      end
    end
  end

  // Registered status pulses
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_ready_reg      <= 1'b0;
      tx_underrun_reg   <= 1'b0;
      new_transfer_reg  <= 1'b0;
      transfer_done_reg <= 1'b0;
    end else begin
      tx_ready_reg      <= do_load & tx_valid;
      tx_underrun_reg   <= do_load & ~tx_valid;
      new_transfer_reg  <= ncs_fall;
      transfer_done_reg <= ncs_rise;
    end
  end

  // FIFO control: a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    fifo_full = (count_reg == FULL_COUNT);
    do_pop    = rx_ready && (count_reg != '0);
    do_push   = word_done && (!fifo_full || do_pop);
  end

  // FIFO storage; contents are only meaningful under count_reg
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= rx_shift_next;
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      rx_overflow_reg <= 1'b0;
    end else begin
      rx_overflow_reg <= word_done & fifo_full & ~do_pop;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Output drive; rx_data is forced to zero while the FIFO is empty
  always_comb begin
    MISO          = LSB_FIRST ? tx_reg[0] : tx_reg[WIDTH-1];
    chip_selected = ~ncs_sync_reg[2];
    miso_oe       = chip_selected;
    rx_valid      = (count_reg != '0);
    rx_data       = rx_valid ? mem[rd_ptr_reg] : '0;
    tx_ready      = tx_ready_reg;
    tx_underrun   = tx_underrun_reg;
    new_transfer  = new_transfer_reg;
    transfer_done = transfer_done_reg;
    rx_overflow   = rx_overflow_reg;
  end

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: four instances, one per SPI mode, driven by a
// bit-level SPI master task; an ordered-list FIFO model predicts RX words.
module tb_spi_slave_fifo;

  localparam int NI = 4;
  localparam int DEPTH_TB = 4;
  // inst0 mode0 MSB-first; inst1 mode1, inst2 mode2, inst3 mode3, LSB-first
  localparam logic [3:0] CPOL_V = 4'b1100;
  localparam logic [3:0] CPHA_V = 4'b1010;
  localparam logic [3:0] LSB_V  = 4'b1110;

  logic clk;
  logic nreset;
  logic ncs [NI];
  logic sck [NI];
  logic mosi [NI];
  logic rx_ready [NI];
  logic tx_valid [NI];
  logic [15:0] tx_data [NI];
  logic [15:0] rx_data [NI];
  logic miso [NI];
  logic miso_oe [NI];
  logic chip_sel [NI];
  logic rx_valid [NI];
  logic tx_ready [NI];
  logic new_tr [NI];
  logic tr_done [NI];
  logic rx_ovf [NI];
  logic tx_und [NI];

  int cnt_rdy [NI];
  int cnt_und [NI];
  int cnt_nt [NI];
  int cnt_td [NI];
  int cnt_ovf [NI];

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] mo_words [8];
  logic [15:0] cap_words [8];
  logic [15:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    spi_slave_fifo #(
      .WIDTH(16), .DEPTH(DEPTH_TB),
      .CPOL(CPOL_V[gi]), .CPHA(CPHA_V[gi]), .LSB_FIRST(LSB_V[gi])
    ) u_dut (
      .clk(clk), .nreset(nreset), .nCS(ncs[gi]), .SCK(sck[gi]), .MOSI(mosi[gi]),
      .MISO(miso[gi]), .miso_oe(miso_oe[gi]), .chip_selected(chip_sel[gi]),
      .rx_data(rx_data[gi]), .rx_valid(rx_valid[gi]), .rx_ready(rx_ready[gi]),
      .tx_data(tx_data[gi]), .tx_valid(tx_valid[gi]), .tx_ready(tx_ready[gi]),
      .new_transfer(new_tr[gi]), .transfer_done(tr_done[gi]),
      .rx_overflow(rx_ovf[gi]), .tx_underrun(tx_und[gi])
    );
  end

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (tx_ready[i] === 1'b1) cnt_rdy[i] <= cnt_rdy[i] + 1;
      if (tx_und[i] === 1'b1)   cnt_und[i] <= cnt_und[i] + 1;
      if (new_tr[i] === 1'b1)   cnt_nt[i]  <= cnt_nt[i] + 1;
      if (tr_done[i] === 1'b1)  cnt_td[i]  <= cnt_td[i] + 1;
      if (rx_ovf[i] === 1'b1)   cnt_ovf[i] <= cnt_ovf[i] + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold after a sample edge; optionally pop exactly in the cycle the word is pushed
  task automatic sample_wait(input int m, input bit pop_now);
    if (pop_now) begin
      wait_clk(2);
      rx_ready[m] = 1'b1;
      wait_clk(1);
      rx_ready[m] = 1'b0;
      wait_clk(5);
    end else begin
      wait_clk(8);
    end
  endtask

  // One chip-select frame: nwords full words, or abort_bits bits if >= 0
  task automatic spi_xfer(input int m, input int nwords, input int abort_bits,
                          input logic [15:0] txw, input logic txv, input bit pop_last,
                          input string nm);
    bit cpol, cpha, lsb;
    int total, full_words, loads_exp, ovf_exp;
    int rdy0, und0, nt0, td0, ovf0, rdy_win, und_win;
    logic [15:0] miso_exp;
    cpol = CPOL_V[m]; cpha = CPHA_V[m]; lsb = LSB_V[m];
    total = (abort_bits >= 0) ? abort_bits : nwords * 16;
    full_words = total / 16;
    loads_exp = (total + 15) / 16;
    ovf_exp = 0; rdy_win = 0; und_win = 0;
    tx_data[m] = txw; tx_valid[m] = txv;
    wait_clk(4);
    rdy0 = cnt_rdy[m]; und0 = cnt_und[m]; nt0 = cnt_nt[m]; td0 = cnt_td[m]; ovf0 = cnt_ovf[m];
    ncs[m] = 1'b0;
    wait_clk(8);
    for (int k = 0; k < total; k++) begin
      int w, idx;
      bit last;
      w = k / 16;
      idx = lsb ? (k % 16) : (15 - (k % 16));
      last = (k == total - 1);
      if (!cpha) begin
        mosi[m] = mo_words[w][idx];
        wait_clk(8);
        cap_words[w][idx] = miso[m];
        sck[m] = ~cpol;
        sample_wait(m, pop_last && last);
      end else begin
        sck[m] = ~cpol;
        mosi[m] = mo_words[w][idx];
        wait_clk(8);
        cap_words[w][idx] = miso[m];
      end
      // Loads that fed the words of this frame (excludes the preload on the final shift edge)
      if (last) begin
        rdy_win = cnt_rdy[m] - rdy0;
        und_win = cnt_und[m] - und0;
      end
      sck[m] = cpol;
      if (cpha) sample_wait(m, pop_last && last);
      else wait_clk(8);
      if ((k % 16) == 15) begin
        if (pop_last && last && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          exp_q.push_back(mo_words[w]);
        end else if (exp_q.size() < DEPTH_TB) begin
          exp_q.push_back(mo_words[w]);
        end else begin
          ovf_exp++;
        end
      end
    end
    ncs[m] = 1'b1;
    wait_clk(8);
    $display("xfer %s inst=%0d bits=%0d tx=%h txv=%b queued=%0d", nm, m, total, txw, txv, exp_q.size());

    n_vec++;
    if (cnt_nt[m] - nt0 !== 1) begin
      n_err++;
      $display("FAIL %s new_transfer pulses: got %0d required 1", nm, cnt_nt[m] - nt0);
    end
    n_vec++;
    if (cnt_td[m] - td0 !== 1) begin
      n_err++;
      $display("FAIL %s transfer_done pulses: got %0d required 1", nm, cnt_td[m] - td0);
    end
    n_vec++;
    if (rdy_win !== (txv ? loads_exp : 0)) begin
      n_err++;
      $display("FAIL %s tx_ready pulses: got %0d required %0d", nm, rdy_win, txv ? loads_exp : 0);
    end
    n_vec++;
    if (und_win !== (txv ? 0 : loads_exp)) begin
      n_err++;
      $display("FAIL %s tx_underrun pulses: got %0d required %0d", nm, und_win, txv ? 0 : loads_exp);
    end
    n_vec++;
    if (cnt_ovf[m] - ovf0 !== ovf_exp) begin
      n_err++;
      $display("FAIL %s rx_overflow pulses: got %0d required %0d", nm, cnt_ovf[m] - ovf0, ovf_exp);
    end
    miso_exp = txv ? txw : 16'hFFFF;
    for (int w = 0; w < full_words; w++) begin
      n_vec++;
      if (cap_words[w] !== miso_exp) begin
        n_err++;
        $display("FAIL %s miso word %0d: got %h required %h", nm, w, cap_words[w], miso_exp);
      end
    end
  endtask

  // Pop every modelled word through the valid/ready port, then require empty
  task automatic drain(input int m, input string nm);
    logic [15:0] want;
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 16) begin
      guard++;
      want = exp_q.pop_front();
      n_vec++;
      if (rx_valid[m] !== 1'b1 || rx_data[m] !== want) begin
        n_err++;
        $display("FAIL %s rx head: valid=%b data=%h required valid=1 data=%h", nm, rx_valid[m], rx_data[m], want);
      end
      rx_ready[m] = 1'b1;
      wait_clk(1);
      rx_ready[m] = 1'b0;
    end
    n_vec++;
    if (rx_valid[m] !== 1'b0) begin
      n_err++;
      $display("FAIL %s fifo empty: rx_valid=%b required 0", nm, rx_valid[m]);
    end
  endtask

  task automatic test_reset;
    logic [8:0] got;
    nreset = 1'b0;
    wait_clk(3);
    for (int i = 0; i < NI; i++) begin
      got = {miso[i], miso_oe[i], chip_sel[i], rx_valid[i], tx_ready[i],
             new_tr[i], tr_done[i], rx_ovf[i], tx_und[i]};
      n_vec++;
      if (got !== 9'b1_0000_0000 || rx_data[i] !== 16'h0000) begin
        n_err++;
        $display("FAIL reset inst%0d outputs: got %b data=%h required 100000000 data=0000", i, got, rx_data[i]);
      end
    end
    nreset = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_mode0;
    mo_words[0] = 16'hA5C3;
    spi_xfer(0, 1, -1, 16'h1234, 1'b1, 1'b0, "mode0");
    drain(0, "mode0");
  endtask

  task automatic test_modes_lsb;
    for (int m = 1; m < NI; m++) begin
      mo_words[0] = 16'h00F1;
      mo_words[1] = 16'h7E01;
      spi_xfer(m, 2, -1, 16'h8E31, 1'b1, 1'b0, "modes");
      drain(m, "modes");
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) mo_words[i] = 16'(i + 1);
    spi_xfer(0, 5, -1, 16'h0F0F, 1'b1, 1'b0, "overflow");
    drain(0, "overflow");
    spi_xfer(0, 5, -1, 16'h0F0F, 1'b1, 1'b1, "overflow_pop");
    drain(0, "overflow_pop");
  endtask

  task automatic test_underrun;
    mo_words[0] = 16'h1357;
    mo_words[1] = 16'h2468;
    spi_xfer(0, 2, -1, 16'h5555, 1'b0, 1'b0, "underrun");
    drain(0, "underrun");
  endtask

  task automatic test_abort;
    mo_words[0] = 16'hFFFF;
    spi_xfer(0, 1, 7, 16'hABCD, 1'b1, 1'b0, "abort");
    drain(0, "abort");
    mo_words[0] = 16'hBEEF;
    spi_xfer(0, 1, -1, 16'hABCD, 1'b1, 1'b0, "abort_next");
    drain(0, "abort_next");
  endtask

  task automatic test_reset_mid;
    mo_words[0] = 16'h1111;
    mo_words[1] = 16'h2222;
    spi_xfer(0, 2, -1, 16'hC0DE, 1'b1, 1'b0, "reset_pre");
    n_vec++;
    if (rx_valid[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre queued: rx_valid=%b required 1", rx_valid[0]);
    end
    ncs[0] = 1'b0;
    wait_clk(8);
    for (int k = 0; k < 9; k++) begin
      mosi[0] = 1'($urandom_range(0, 1));
      wait_clk(8);
      sck[0] = 1'b1;
      wait_clk(8);
      sck[0] = 1'b0;
    end
    wait_clk(3);
    nreset = 1'b0;
    wait_clk(2);
    n_vec++;
    if ({rx_valid[0], miso[0], miso_oe[0]} !== 3'b010) begin
      n_err++;
      $display("FAIL reset_mid outputs: valid/miso/oe=%b required 010", {rx_valid[0], miso[0], miso_oe[0]});
    end
    ncs[0] = 1'b1;
    wait_clk(4);
    nreset = 1'b1;
    exp_q.delete();
    wait_clk(8);
    mo_words[0] = 16'h5A5A;
    spi_xfer(0, 1, -1, 16'h3C3C, 1'b1, 1'b0, "reset_post");
    drain(0, "reset_post");
  endtask

  task automatic test_random;
    for (int t = 0; t < 6; t++) begin
      int m, nw;
      m = $urandom_range(0, NI - 1);
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) mo_words[i] = 16'($urandom);
      spi_xfer(m, nw, -1, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, "random");
      drain(m, "random");
    end
  endtask

  initial begin
    nreset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      ncs[i] = 1'b1;
      sck[i] = CPOL_V[i];
      mosi[i] = 1'b0;
      rx_ready[i] = 1'b0;
      tx_valid[i] = 1'b0;
      tx_data[i] = 16'h0000;
    end
    test_reset();
    test_mode0();
    test_modes_lsb();
    test_overflow();
    test_underrun();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_fifo.md
# spi_slave_fifo

Parametrised full-duplex SPI slave for the fabric clock domain. It supports all four SPI modes, a configurable word width and bit order, an RX FIFO with valid/ready drain, and a TX word port with valid/ready load that drives MISO. It sits between the external SPI pins and the CPU/bus side, and is the next generation of the receive-only 16-bit shift slave.

## Interface
Parameters:
- WIDTH, 16, bits per word; ≥ 2.
- DEPTH, 4, RX FIFO entries; power of two, ≥ 2.
- CPOL, 0, SCK idle level.
- CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
- LSB_FIRST, 0, 1 = bit 0 shifted first on both MOSI and MISO.

Ports:
- clk  in  1  fabric clock; all logic on posedge.
- nreset  in  1  reset; asynchronous, active-low.
- nCS  in  1  async chip select, active-low.
- SCK  in  1  async SPI clock.
- MOSI  in  1  async serial in.
- MISO  out  1  serial out; the current TX shift bit.
- miso_oe  out  1  MISO tristate enable; equals chip_selected.
- chip_selected  out  1  synchronised, inverted nCS.
- rx_data  out  WIDTH  FIFO head (first-word fall-through).
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  pop head when rx_valid && rx_ready.
- tx_data  in  WIDTH  next word to transmit.
- tx_valid  in  1  tx_data is available.
- tx_ready  out  1  1-cycle pulse: tx_data consumed this cycle.
- new_transfer  out  1  1-cycle pulse on nCS falling.
- transfer_done  out  1  1-cycle pulse on nCS rising.
- rx_overflow  out  1  1-cycle pulse: completed word dropped because the FIFO was full.
- tx_underrun  out  1  1-cycle pulse: word load with tx_valid=0.

## Operation
- **Synchronisers.** nCS and SCK each pass through 3 flops; edges are detected on flops [2:1]. MOSI passes through 2 flops, aligned with the SCK edge detect.
- **Sync reset values.** On reset, the nCS synchroniser flops go to 1 and the SCK synchroniser flops go to CPOL. No false edge is produced after reset.
- **Edge roles.**
  - Sample edge is rising when CPOL==CPHA, falling otherwise.
  - Shift edge is the opposite edge.
- **RX path.**
  - On each sample edge while selected: shift MOSI_sync in (MSB-first: into bit 0 shifting left; LSB-first: into bit WIDTH-1 shifting right) and increment bitcnt.
  - bitcnt is $clog2(WIDTH) bits wide. At bitcnt==WIDTH-1 it wraps to 0 and the assembled word is pushed.
- **TX load.**
  - A load takes tx_data and pulses tx_ready if tx_valid; otherwise it takes all-ones and pulses tx_underrun.
  - Loads occur on nCS falling.
  - Loads also occur at the first shift edge after a completed word (the pending flag is set at the last sample edge).
- **TX shift.**
  - On other shift edges the TX register shifts toward its output end.
  - When CPHA=1, the first shift edge after nCS falling is ignored, because bit 0 is already presented.
  - MISO = TX MSB (or LSB when LSB_FIRST=1), driven straight from the register.
- **FIFO.**
  - Circular buffer with a count of $clog2(DEPTH)+1 bits.
  - Push when full: the word is dropped and rx_overflow pulses.
  - Push when full with a pop in the same cycle: both occur and there is no overflow.
  - Pop when empty: ignored.
- **Deselect mid-word.** On nCS rising: bitcnt←0, load-pending cleared, and partial RX bits discarded (no push). The partially sent TX word is lost. FIFO contents are kept.
- **Async reset.** nreset low clears FIFO, counters, shift registers (TX to all-ones) and all pulses, regardless of transfer state.

## Timing
- Every output is 0 during reset except MISO, which is 1 (miso_oe is 0).
- Cycle T is the cycle in which an edge is visible on sync flops [2:1].
- new_transfer and transfer_done are high in T+1.
- TX load on nCS falling completes at the end of T; tx_ready/tx_underrun are high in T+1.
- Sample edge of the last bit at T: rx_valid rises and rx_data is valid in T+1; rx_overflow, if any, is in T+1.
- Shift edge at T: MISO changes in T+1. Pin-to-MISO latency is 4 clk.
- SCK high and low phases must each be ≥ 4 clk.
- nCS falling to first SCK edge must be ≥ 4 clk.
- tx_data must be valid ≥ 3 clk before nCS falls, and before the shift edge following each word.
- Pop is registered: rx_valid/rx_data reflect the new head in the cycle after the pop.

## Test plan
- **Mode 0 round trip.** WIDTH=16, MSB-first, tx_data=0x1234 held valid; master sends 0xA5C3. Required: MISO bits read 0x1234, rx_data=0xA5C3, one tx_ready pulse, new_transfer and transfer_done one pulse each.
- **Modes 1/2/3 and LSB-first.** Master sends 0x00F1 in each mode, LSB_FIRST=1. Required: rx_data=0x00F1 and MISO bit order correct in every mode.
- **Overflow.** DEPTH=4, five back-to-back words 1..5, rx_ready=0. Required: FIFO holds 1..4, rx_overflow pulses once at word 5. Repeat with rx_ready=1 in the push cycle: no overflow.
- **Underrun.** tx_valid=0, two words. Required: MISO all ones, two tx_underrun pulses.
- **Abort.** nCS rises after 7 bits. Required: no push, transfer_done pulse; the next full word 0xBEEF is received intact.
- **Reset mid-transfer.** nreset low at bit 9 with 2 words queued. Required: rx_valid=0, MISO=1, miso_oe=0; after release, clean reception of 0x5A5A.
